mips_multicycle_control: RTL
============================

# mips_multicycle_control

Main control unit for the multicycle MIPS datapath. A Moore-style FSM, with one Mealy term on `jumpreg`, that sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable plus the 3-bit `aluop` consumed by the ALU control decoder. It also takes back that decoder's `jumpreg` flag to complete `jr`.

## Interface
Parameters:
- `OPW`, 6, opcode width.
- `AOPW`, 3, aluop width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  6  instruction[31:26] from IR; stable from DECODE onward.
- `jumpreg`  in  1  from ALU control; 1 when the R-type funct is 0x08.
- `aluop`  out  3  000 add, 001 sub, 010 R-type (use funct), 011 and, 100 or.
- `alusrca`  out  1  0 = PC, 1 = rs.
- `alusrcb`  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `pcwrite`, `pcwritecond`  out  1 each  unconditional PC load / PC load if ALU zero.
- `pcsource`  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
- `iord`  out  1  0 = PC address, 1 = ALUOut address.
- `memread`, `memwrite`, `irwrite`, `regwrite`  out  1 each  write/read enables.
- `regdst`  out  2  00 rt, 01 rd, 10 $31.
- `memtoreg`  out  2  00 ALUOut, 01 MDR, 10 PC.
- `instr_done`  out  1  high in the last cycle of every instruction.
- `illegal`  out  1  high in DECODE for an unsupported opcode.

## Operation
- State register is 4 bits and resets asynchronously to FETCH. Codes: FETCH0, DECODE1, MEMADR2, MEMRD3, MEMWB4, MEMWR5, RTEXEC6, RTWB7, BEQEX8, IMMEX9, IMMWB10, JEX11, JALEX12. Codes 13–15 go to FETCH.
- Every output defaults to 0 unless listed for the current state.
- FETCH: `memread`, `irwrite`, `pcwrite` = 1; `alusrcb` = 01; `aluop` = 000. Next state is DECODE.
- DECODE: `alusrcb` = 11; `aluop` = 000 (branch target precompute). Next state by opcode:
  - 0x23 or 0x2B → MEMADR.
  - 0x00 → RTEXEC.
  - 0x04 → BEQEX.
  - 0x08, 0x0C, 0x0D → IMMEX.
  - 0x02 → JEX.
  - 0x03 → JALEX.
  - anything else → FETCH, with `illegal` = 1 and `instr_done` = 1.
- MEMADR: `alusrca` = 1, `alusrcb` = 10, `aluop` = 000. Next state is MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: `memread` = 1, `iord` = 1. Next state is MEMWB.
- MEMWB: `regwrite` = 1, `regdst` = 00, `memtoreg` = 01. Next state is FETCH.
- MEMWR: `memwrite` = 1, `iord` = 1. Next state is FETCH.
- RTEXEC: `alusrca` = 1, `alusrcb` = 00, `aluop` = 010.
  - If `jumpreg` = 1: `pcwrite` = 1, `pcsource` = 11, `instr_done` = 1, next state FETCH (no writeback).
  - Otherwise next state is RTWB.
- RTWB: `regwrite` = 1, `regdst` = 01, `memtoreg` = 00. Next state is FETCH.
- BEQEX: `alusrca` = 1, `alusrcb` = 00, `aluop` = 001, `pcwritecond` = 1, `pcsource` = 01. Next state is FETCH.
- IMMEX: `alusrca` = 1, `alusrcb` = 10. `aluop` is 000 for 0x08, 011 for 0x0C, 100 for 0x0D. Next state is IMMWB.
- IMMWB: `regwrite` = 1, `regdst` = 00, `memtoreg` = 00. Next state is FETCH.
- JEX: `pcwrite` = 1, `pcsource` = 10. Next state is FETCH.
- JALEX: `pcwrite` = 1, `pcsource` = 10, `regwrite` = 1, `regdst` = 10, `memtoreg` = 10. Next state is FETCH.
- `instr_done` = 1 in every state whose next state is FETCH.

## Timing
- Outputs are combinational from the state register and `opcode`; only `pcwrite`, `pcsource` and `instr_done` in RTEXEC also depend on `jumpreg`.
- Cycles per instruction, counted from FETCH inclusive:
  - lw 5
  - sw, R-type, immediates 4
  - beq, j, jal, jr 3
  - illegal 2
- Reset behaviour:
  - While `reset` = 1, the outputs `pcwrite`, `pcwritecond`, `irwrite`, `regwrite`, `memwrite`, `memread`, `instr_done` and `illegal` are forced to 0.
  - The other outputs take their FETCH values.
- Reset asserted mid-instruction aborts it immediately; no write enable is asserted for the remainder.
- The first rising edge after `reset` falls executes FETCH.
- `jumpreg` is sampled only in RTEXEC and ignored in all other states.

## Configuration
- `MC_JAL_EN`:
  - Defined: JALEX exists and opcode 0x03 executes as above.
  - Undefined: JALEX is absent; 0x03 is treated as illegal, and `regdst` = 10 and `memtoreg` = 10 are never driven.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants
  - aluop encodings (shared with ALU control)
  - `alusrcb`, `pcsource`, `regdst` and `memtoreg` encodings
  - the state enum
- One sub-module, `mc_state_decode`: a purely combinational state+opcode → control-word decoder. The top holds only the state register, next-state logic and reset gating.

## Test plan
- Reset pulse mid-MEMRD → state returns to FETCH asynchronously, every write enable stays 0, and the next lw completes in 5 cycles with `regwrite` = 1 in MEMWB.
- sw (0x2B) → `memwrite` = 1 with `iord` = 1 in cycle 4, and `instr_done` = 1 in that same cycle.
- R-type with `jumpreg` = 0 → `aluop` = 010 in cycle 3, `regwrite` = 1 with `regdst` = 01 in cycle 4. With `jumpreg` = 1 → `pcwrite` = 1 with `pcsource` = 11 in cycle 3, and no `regwrite`.
- Opcodes 0x0C and 0x0D → `aluop` = 011 and 100 respectively in IMMEX; beq → `aluop` = 001 with `pcwritecond` = 1 in cycle 3.
- Opcode 0x3F → `illegal` = 1 in DECODE and FETCH on the next cycle. Opcode 0x03 → JALEX writes $31 with `MC_JAL_EN` defined, and raises `illegal` without it.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, aluop, mux selects, FSM states.
// MC_JAL_EN adds the JALEX state and makes opcode 0x03 legal.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
`ifdef MC_JAL_EN
    S_JEX    = 4'd11,
    S_JALEX  = 4'd12
`else
    S_JEX    = 4'd11
`endif
  } state_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_legal = 1'b1;
`ifdef MC_JAL_EN
      OP_JAL: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_state_decode.sv
// Combinational state+opcode to control-word decoder; jumpreg only matters in RTEXEC.
// MC_JAL_EN enables the JALEX control word.
module mc_state_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       jumpreg,
  output ctrl_t      cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.memread = 1'b1;
        cw.irwrite = 1'b1;
        cw.pcwrite = 1'b1;
        cw.alusrcb = SRCB_FOUR;
        cw.aluop   = ALU_ADD;
      end
      S_DECODE: begin
        cw.alusrcb    = SRCB_IMMSH;
        cw.aluop      = ALU_ADD;
        cw.illegal    = !op_legal(opcode);
        cw.instr_done = !op_legal(opcode);
      end
      S_MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        cw.memread = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEMWB: begin
        cw.regwrite   = 1'b1;
        cw.regdst     = DST_RT;
        cw.memtoreg   = WB_MDR;
        cw.instr_done = 1'b1;
      end
      S_MEMWR: begin
        cw.memwrite   = 1'b1;
        cw.iord       = 1'b1;
        cw.instr_done = 1'b1;
      end
      S_RTEXEC: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RT;
        cw.aluop   = ALU_RTYPE;
        // jr completes here straight from rs; no writeback cycle follows
        if (jumpreg) begin
          cw.pcwrite    = 1'b1;
          cw.pcsource   = PCSRC_RS;
          cw.instr_done = 1'b1;
        end
      end
      S_RTWB: begin
        cw.regwrite   = 1'b1;
        cw.regdst     = DST_RD;
        cw.memtoreg   = WB_ALUOUT;
        cw.instr_done = 1'b1;
      end
      S_BEQEX: begin
        cw.alusrca     = 1'b1;
        cw.alusrcb     = SRCB_RT;
        cw.aluop       = ALU_SUB;
        cw.pcwritecond = 1'b1;
        cw.pcsource    = PCSRC_ALUOUT;
        cw.instr_done  = 1'b1;
      end
      S_IMMEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        case (opcode)
          OP_ANDI: cw.aluop = ALU_AND;
          OP_ORI:  cw.aluop = ALU_OR;
          default: cw.aluop = ALU_ADD;
        endcase
      end
      S_IMMWB: begin
        cw.regwrite   = 1'b1;
        cw.regdst     = DST_RT;
        cw.memtoreg   = WB_ALUOUT;
        cw.instr_done = 1'b1;
      end
      S_JEX: begin
        cw.pcwrite    = 1'b1;
        cw.pcsource   = PCSRC_JUMP;
        cw.instr_done = 1'b1;
      end
`ifdef MC_JAL_EN
      S_JALEX: begin
        cw.pcwrite    = 1'b1;
        cw.pcsource   = PCSRC_JUMP;
        cw.regwrite   = 1'b1;
        cw.regdst     = DST_RA;
        cw.memtoreg   = WB_PC;
        cw.instr_done = 1'b1;
      end
`endif
      default: cw.instr_done = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: state register, next-state logic and reset gating of enables.
// MC_JAL_EN adds jal support via the JALEX state.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int AOPW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            jumpreg,
  output logic [AOPW-1:0] aluop,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic            pcwrite,
  output logic            pcwritecond,
  output logic [1:0]      pcsource,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regwrite,
  output logic [1:0]      regdst,
  output logic [1:0]      memtoreg,
  output logic            instr_done,
  output logic            illegal
);

  state_t state;
  state_t state_nxt;
  ctrl_t  cw;

  mc_state_decode u_decode (
    .state   (state),
    .opcode  (opcode),
    .jumpreg (jumpreg),
    .cw      (cw)
  );

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:              state_nxt = S_MEMADR;
          OP_RTYPE:                  state_nxt = S_RTEXEC;
          OP_BEQ:                    state_nxt = S_BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI:  state_nxt = S_IMMEX;
          OP_J:                      state_nxt = S_JEX;
`ifdef MC_JAL_EN
          OP_JAL:                    state_nxt = S_JALEX;
`endif
          default:                   state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_RTEXEC: state_nxt = jumpreg ? S_FETCH : S_RTWB;
      S_IMMEX:  state_nxt = S_IMMWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // State is already FETCH during reset, so only the enables need masking
  assign aluop       = cw.aluop;
  assign alusrca     = cw.alusrca;
  assign alusrcb     = cw.alusrcb;
  assign pcsource    = cw.pcsource;
  assign iord        = cw.iord;
  assign regdst      = cw.regdst;
  assign memtoreg    = cw.memtoreg;
  assign pcwrite     = cw.pcwrite     & ~reset;
  assign pcwritecond = cw.pcwritecond & ~reset;
  assign irwrite     = cw.irwrite     & ~reset;
  assign regwrite    = cw.regwrite    & ~reset;
  assign memwrite    = cw.memwrite    & ~reset;
  assign memread     = cw.memread     & ~reset;
  assign instr_done  = cw.instr_done  & ~reset;
  assign illegal     = cw.illegal     & ~reset;

endmodule
